// File: rtl/ring_phase_monitor.sv
// One-hot ring counter monitor: legality/rotation check, phase lock,
// slot encode, revolution counting and sticky fault capture.
module ring_phase_monitor #(
  parameter int BITS     = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic                     clk,
  input  logic                     ORI,
  input  logic                     en,
  input  logic [BITS-1:0]          Q,
  input  logic                     clr_err,
  output logic [$clog2(BITS)-1:0]  slot,
  output logic                     slot_vld,
  output logic                     wrap,
  output logic [REV_W-1:0]         rev_cnt,
  output logic                     locked,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int SW = $clog2(BITS);
  localparam int CW = $clog2(LOCK_CNT + 1);
  // Bit that q_prev must occupy for a step to complete a revolution
  localparam int WB = (DIR == 0) ? BITS - 1 : 0;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t            state, n_state;
  logic [BITS-1:0]   q_prev, n_q_prev;
  logic [CW-1:0]     match_cnt, n_match_cnt;
  logic [CW-1:0]     cnt_inc;
  logic [SW-1:0]     n_slot, q_idx;
  logic              n_slot_vld, n_wrap, n_locked, n_err;
  logic [REV_W-1:0]  n_rev_cnt;
  logic [1:0]        n_err_code;
  logic [BITS-1:0]   rot_prev, expected;
  logic              onehot, match;

  // Rotation of the previous sample, legality and step-match decode
  always_comb begin
    if (DIR == 0) rot_prev = {q_prev[BITS-2:0], q_prev[BITS-1]};
    else          rot_prev = {q_prev[0], q_prev[BITS-1:1]};
    expected = en ? rot_prev : q_prev;
    match    = (Q == expected);
    onehot   = (Q != '0) && ((Q & (Q - BITS'(1))) == '0);
    cnt_inc  = match_cnt + CW'(1);
  end

  // Binary index of the set bit of Q
  always_comb begin
    q_idx = '0;
    for (int i = 0; i < BITS; i++) begin
      if (Q[i]) q_idx = SW'(i);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    n_state     = state;
    n_q_prev    = Q;
    n_match_cnt = match_cnt;
    n_slot      = slot;
    n_slot_vld  = slot_vld;
    n_wrap      = 1'b0;
    n_rev_cnt   = rev_cnt;
    n_locked    = locked;
    n_err       = err;
    n_err_code  = err_code;
    unique case (state)
      SYNC: begin
        if (onehot) begin
          n_match_cnt = '0;
          n_state     = TRACK;
        end
      end
      TRACK: begin
        if (match) begin
          n_match_cnt = cnt_inc;
          if (cnt_inc == CW'(LOCK_CNT)) begin
            n_state    = LOCKED;
            n_locked   = 1'b1;
            n_slot_vld = 1'b1;
            n_slot     = q_idx;
          end
        end else begin
          n_match_cnt = '0;
          n_state     = SYNC;
        end
      end
      LOCKED: begin
        if (match) begin
          n_slot = q_idx;
          if (en && q_prev[WB]) begin
            n_wrap    = 1'b1;
            n_rev_cnt = rev_cnt + REV_W'(1);
          end
        end else begin
          n_state    = FAULT;
          n_err      = 1'b1;
          n_locked   = 1'b0;
          n_slot_vld = 1'b0;
          if (!onehot)  n_err_code = 2'b01;
          else if (!en) n_err_code = 2'b11;
          else          n_err_code = 2'b10;
        end
      end
      FAULT: begin
        if (clr_err) begin
          n_err       = 1'b0;
          n_err_code  = 2'b00;
          n_rev_cnt   = '0;
          n_match_cnt = '0;
          n_state     = SYNC;
        end
      end
      default: n_state = SYNC;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge ORI) begin
    if (ORI) begin
      state     <= SYNC;
      q_prev    <= '0;
      match_cnt <= '0;
      slot      <= '0;
      slot_vld  <= 1'b0;
      wrap      <= 1'b0;
      rev_cnt   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= n_state;
      q_prev    <= n_q_prev;
      match_cnt <= n_match_cnt;
      slot      <= n_slot;
      slot_vld  <= n_slot_vld;
      wrap      <= n_wrap;
      rev_cnt   <= n_rev_cnt;
      locked    <= n_locked;
      err       <= n_err;
      err_code  <= n_err_code;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor (BITS=4, DIR=0, LOCK_CNT=2).
// Linear stimulus, immediate-assert checks, one summary line.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       ORI;
  logic       en;
  logic [3:0] Q;
  logic       clr_err;
  logic [1:0] slot;
  logic       slot_vld;
  logic       wrap;
  logic [7:0] rev_cnt;
  logic       locked;
  logic       err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  ring_phase_monitor #(
    .BITS(4), .DIR(0), .LOCK_CNT(2), .REV_W(8)
  ) dut (
    .clk(clk), .ORI(ORI), .en(en), .Q(Q), .clr_err(clr_err),
    .slot(slot), .slot_vld(slot_vld), .wrap(wrap),
    .rev_cnt(rev_cnt), .locked(locked), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, let an edge take it, settle 1 time unit.
  task automatic step(input logic [3:0] q, input logic e);
    Q  = q;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lock(input string tag, input logic l,
                          input logic [1:0] s);
    chk({tag, "_locked"}, 32'(locked), 32'(l));
    chk({tag, "_vld"}, 32'(slot_vld), 32'(l));
    if (l) chk({tag, "_slot"}, 32'(slot), 32'(s));
  endtask

  initial begin
    ORI = 1'b1; en = 1'b0; Q = 4'b0000; clr_err = 1'b0;
    @(posedge clk); #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_vld", 32'(slot_vld), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_rev", 32'(rev_cnt), 0);
    chk("rst_wrap", 32'(wrap), 0);
    ORI = 1'b0;

    // Non-one-hot while in SYNC raises nothing
    step(4'b0000, 1'b1);
    chk("sync_zero_err", 32'(err), 0);

    // Lock-in and first revolution
    step(4'b0001, 1'b1); chk_lock("t2a", 1'b0, 2'd0);
    step(4'b0010, 1'b1); chk_lock("t2b", 1'b0, 2'd0);
    step(4'b0100, 1'b1); chk_lock("t2c", 1'b1, 2'd2);
    step(4'b1000, 1'b1); chk_lock("t2d", 1'b1, 2'd3);
    chk("t2d_wrap", 32'(wrap), 0);
    step(4'b0001, 1'b1); chk_lock("t2e", 1'b1, 2'd0);
    chk("t2e_wrap", 32'(wrap), 1);
    chk("t2e_rev", 32'(rev_cnt), 1);
    step(4'b0010, 1'b1);
    chk("t2f_wrap", 32'(wrap), 0);
    chk("t2f_rev", 32'(rev_cnt), 1);

    // Hold with en=0 while locked
    step(4'b0100, 1'b1); chk_lock("t6a", 1'b1, 2'd2);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1'b0);
      chk_lock("t6_hold", 1'b1, 2'd2);
      chk("t6_hold_wrap", 32'(wrap), 0);
      chk("t6_hold_err", 32'(err), 0);
    end

    // Move while en=0 -> code 11
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    chk("t4_rev2", 32'(rev_cnt), 2);
    step(4'b0010, 1'b1); chk_lock("t4a_pre", 1'b1, 2'd1);
    step(4'b0100, 1'b0);
    chk("t4a_err", 32'(err), 1);
    chk("t4a_code", 32'(err_code), 2'b11);
    chk_lock("t4a", 1'b0, 2'd0);
    clr_err = 1'b1;
    step(4'b1000, 1'b1);
    clr_err = 1'b0;
    chk("t4a_clr_err", 32'(err), 0);
    chk("t4a_clr_code", 32'(err_code), 0);
    chk("t4a_clr_rev", 32'(rev_cnt), 0);

    // Wrong step with en=1 -> code 10, clr_err on the same edge loses
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1); chk_lock("t4b_lock", 1'b1, 2'd2);
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    clr_err = 1'b1;
    step(4'b1000, 1'b1);
    clr_err = 1'b0;
    chk("t4b_err", 32'(err), 1);
    chk("t4b_code", 32'(err_code), 2'b10);
    chk_lock("t4b", 1'b0, 2'd0);
    clr_err = 1'b1;
    step(4'b0000, 1'b1);
    clr_err = 1'b0;
    chk("t4b_clr", 32'(err), 0);

    // Not one-hot while locked -> code 01, held for 10 cycles
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    chk("t3_rev", 32'(rev_cnt), 1);
    step(4'b0011, 1'b1);
    chk("t3_err", 32'(err), 1);
    chk("t3_code", 32'(err_code), 2'b01);
    chk_lock("t3", 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step(4'(1 << (i % 4)), 1'b1);
      chk("t3_hold_err", 32'(err), 1);
      chk("t3_hold_code", 32'(err_code), 2'b01);
      chk("t3_hold_lock", 32'(locked), 0);
      chk("t3_hold_rev", 32'(rev_cnt), 1);
    end
    clr_err = 1'b1;
    step(4'b0001, 1'b1);
    clr_err = 1'b0;
    chk("t3_clr_err", 32'(err), 0);
    chk("t3_clr_rev", 32'(rev_cnt), 0);
    step(4'b0001, 1'b1); chk_lock("t3_r1", 1'b0, 2'd0);
    step(4'b0010, 1'b1); chk_lock("t3_r2", 1'b0, 2'd0);
    step(4'b0100, 1'b1); chk_lock("t3_r3", 1'b1, 2'd2);
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    chk("t1_pre_rev", 32'(rev_cnt), 1);

    // Async reset mid-revolution
    step(4'b0010, 1'b1);
    #2 ORI = 1'b1;
    #1;
    chk("t1_async_locked", 32'(locked), 0);
    chk("t1_async_vld", 32'(slot_vld), 0);
    chk("t1_async_err", 32'(err), 0);
    chk("t1_async_rev", 32'(rev_cnt), 0);
    @(posedge clk); #1;
    ORI = 1'b0;
    step(4'b1000, 1'b1); chk_lock("t1_r1", 1'b0, 2'd0);
    step(4'b0001, 1'b1); chk_lock("t1_r2", 1'b0, 2'd0);
    step(4'b0010, 1'b1); chk_lock("t1_r3", 1'b1, 2'd1);
    chk("t1_r3_err", 32'(err), 0);

    // Pre-lock mismatch returns to SYNC silently
    ORI = 1'b1;
    @(posedge clk); #1;
    ORI = 1'b0;
    step(4'b0001, 1'b1);
    step(4'b0100, 1'b1);
    chk("t5_err", 32'(err), 0);
    chk_lock("t5_a", 1'b0, 2'd0);
    step(4'b0010, 1'b1); chk_lock("t5_b", 1'b0, 2'd0);
    step(4'b0100, 1'b1); chk_lock("t5_c", 1'b0, 2'd0);
    step(4'b1000, 1'b1); chk_lock("t5_d", 1'b1, 2'd3);
    chk("t5_d_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
